// File: rtl/clut_videogen_pipeline.sv
// clut_videogen_pipeline
//   Palette-lookup video output stage. A pixel index and bank select are
//   registered onto an external colour memory bus. The returned {B,G,R} word
//   is scaled by a frame-rate fade level and registered onto the colour
//   outputs. SYNC and BLANK follow through delay taps, so they stay aligned
//   with the colour data.
// Ports
//   CLK_6MD, reset      pixel clock; synchronous active-high reset
//   enable              pixel clock enable; when low, every register holds
//   D, BANK             palette index and bank; prom_addr = {BANK,D}, registered
//   SYNC_IN, BLANK_IN   sync and blank, aligned with D
//   SYNC, BLANK         sync and blank, delayed to line up with RED/GREEN/BLUE
//   RED, GREEN, BLUE    scaled colour outputs
//   prom_addr, prom_ce  colour memory address and enable (prom_ce = enable)
//   prom_data           colour memory read data {B,G,R}
//   fade_start/dir/rate fade request; dir 0 = fade out, 1 = fade in;
//                       frames per step = fade_rate+1
//   fade_busy, fade_done  fade in progress; one-cycle pulse when a fade ends
module clut_videogen_pipeline #(
  parameter int unsigned INDEX_W      = 8,
  parameter int unsigned BANK_W       = 1,
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned PROM_LATENCY = 1,
  parameter int unsigned RATE_W       = 4
) (
  input  logic                        CLK_6MD,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [INDEX_W-1:0]          D,
  input  logic [BANK_W-1:0]           BANK,
  input  logic                        SYNC_IN,
  input  logic                        BLANK_IN,
  output logic                        SYNC,
  output logic                        BLANK,
  output logic [COLOR_W-1:0]          RED,
  output logic [COLOR_W-1:0]          GREEN,
  output logic [COLOR_W-1:0]          BLUE,
  output logic [BANK_W+INDEX_W-1:0]   prom_addr,
  output logic                        prom_ce,
  input  logic [3*COLOR_W-1:0]        prom_data,
  input  logic                        fade_start,
  input  logic                        fade_dir,
  input  logic [RATE_W-1:0]           fade_rate,
  output logic                        fade_busy,
  output logic                        fade_done
);

  localparam int unsigned ADDR_W = BANK_W + INDEX_W;
  localparam int unsigned TAPS   = PROM_LATENCY + 1;
  localparam int unsigned PROD_W = 2 * COLOR_W + 1;
  localparam logic [COLOR_W-1:0] LEVEL_MAX = '1;

  typedef enum logic [0:0] {S_IDLE, S_RAMP} state_t;

  // Scale one channel by (level+1)/2^COLOR_W, rounding down
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [COLOR_W-1:0] lvl);
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(PROD_W'(lvl) + PROD_W'(1));
    return COLOR_W'(p >> COLOR_W);
  endfunction

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [TAPS-1:0]    sync_tap_q, sync_tap_d;
  logic [TAPS-1:0]    blank_tap_q, blank_tap_d;
  logic               sync_out_q, sync_out_d;
  logic               blank_out_q, blank_out_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               sync_prev_q, sync_prev_d;
  state_t             state_q, state_d;
  logic [COLOR_W-1:0] level_q, level_d;
  logic               dir_q, dir_d;
  logic [RATE_W-1:0]  rate_q, rate_d;
  logic [RATE_W-1:0]  cnt_q, cnt_d;
  logic               done_q, done_d;

  logic               frame_tick_c;
  logic               blank_dly_c;
  logic [COLOR_W-1:0] start_target_c;
  logic [COLOR_W-1:0] ramp_target_c;
  logic [COLOR_W-1:0] level_step_c;

  // Pixel pipeline: address stage, sync/blank taps, scaled colour output
  always_comb begin
    addr_d      = {BANK, D};
    sync_tap_d  = {sync_tap_q[TAPS-2:0], SYNC_IN};
    blank_tap_d = {blank_tap_q[TAPS-2:0], BLANK_IN};
    // The last tap lines up with the memory data for the same pixel
    blank_dly_c = blank_tap_q[TAPS-1];
    sync_out_d  = sync_tap_q[TAPS-1];
    blank_out_d = blank_dly_c;
    red_d       = blank_dly_c ? '0 : scale(prom_data[COLOR_W-1:0], level_q);
    green_d     = blank_dly_c ? '0 : scale(prom_data[2*COLOR_W-1:COLOR_W], level_q);
    blue_d      = blank_dly_c ? '0 : scale(prom_data[3*COLOR_W-1:2*COLOR_W], level_q);
  end

  // Fade engine: frame tick on the SYNC_IN rising edge, level ramps one step per rate+1 ticks
  always_comb begin
    sync_prev_d    = SYNC_IN;
    frame_tick_c   = SYNC_IN & ~sync_prev_q;
    state_d        = state_q;
    level_d        = level_q;
    dir_d          = dir_q;
    rate_d         = rate_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    start_target_c = fade_dir ? LEVEL_MAX : '0;
    ramp_target_c  = dir_q ? LEVEL_MAX : '0;
    // Saturating step toward the target
    if (dir_q) begin
      level_step_c = (level_q == LEVEL_MAX) ? level_q : level_q + COLOR_W'(1);
    end else begin
      level_step_c = (level_q == '0) ? level_q : level_q - COLOR_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        // A start request takes priority over a tick arriving in the same cycle
        if (fade_start) begin
          if (level_q == start_target_c) begin
            done_d = 1'b1;
          end else begin
            dir_d   = fade_dir;
            rate_d  = fade_rate;
            cnt_d   = '0;
            state_d = S_RAMP;
          end
        end
      end
      S_RAMP: begin
        if (frame_tick_c) begin
          if (cnt_q == rate_q) begin
            cnt_d   = '0;
            level_d = level_step_c;
            if (level_step_c == ramp_target_c) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over enable; otherwise everything advances only on enabled cycles
  always_ff @(posedge CLK_6MD) begin
    if (reset) begin
      addr_q      <= '0;
      sync_tap_q  <= '0;
      blank_tap_q <= '1;
      sync_out_q  <= 1'b0;
      blank_out_q <= 1'b1;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      sync_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      level_q     <= LEVEL_MAX;
      dir_q       <= 1'b0;
      rate_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else if (enable) begin
      addr_q      <= addr_d;
      sync_tap_q  <= sync_tap_d;
      blank_tap_q <= blank_tap_d;
      sync_out_q  <= sync_out_d;
      blank_out_q <= blank_out_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      sync_prev_q <= sync_prev_d;
      state_q     <= state_d;
      level_q     <= level_d;
      dir_q       <= dir_d;
      rate_q      <= rate_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  assign prom_addr = addr_q;
  assign prom_ce   = enable;
  assign SYNC      = sync_out_q;
  assign BLANK     = blank_out_q;
  assign RED       = red_q;
  assign GREEN     = green_q;
  assign BLUE      = blue_q;
  assign fade_busy = (state_q == S_RAMP);
  assign fade_done = done_q;

endmodule

// File: tb/tb_clut_videogen_pipeline.sv
// Bench for clut_videogen_pipeline: table-driven pixel stream checked through
// an output scoreboard, plus hand-written fade and reset sequences.
module tb_clut_videogen_pipeline;

  typedef struct packed {
    logic       sync;
    logic       blank;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } out_t;

  typedef struct {
    logic       en;
    logic [0:0] bank;
    logic [7:0] d;
    logic       sync;
    logic       blank;
    out_t       exp;
  } vec_t;

  localparam out_t BUBBLE = '{sync: 1'b0, blank: 1'b1, r: 4'h0, g: 4'h0, b: 4'h0};

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  D;
  logic [0:0]  BANK;
  logic        SYNC_IN, BLANK_IN;
  logic        SYNC, BLANK;
  logic [3:0]  RED, GREEN, BLUE;
  logic [8:0]  prom_addr;
  logic        prom_ce;
  logic [11:0] prom_data = 12'h000;
  logic        fade_start, fade_dir;
  logic [3:0]  fade_rate;
  logic        fade_busy, fade_done;

  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  out_t exp_q[$];
  out_t last_out;

  clut_videogen_pipeline dut (
    .CLK_6MD(clk), .reset(reset), .enable(enable), .D(D), .BANK(BANK),
    .SYNC_IN(SYNC_IN), .BLANK_IN(BLANK_IN), .SYNC(SYNC), .BLANK(BLANK),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .prom_addr(prom_addr),
    .prom_ce(prom_ce), .prom_data(prom_data), .fade_start(fade_start),
    .fade_dir(fade_dir), .fade_rate(fade_rate), .fade_busy(fade_busy),
    .fade_done(fade_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] mem_word(input logic [8:0] a);
    logic [11:0] t;
    if (a == 9'h135) return 12'hA5C;
    if (a == 9'h0FF) return 12'hFFF;
    t = {3'b000, a};
    return 12'((t * 12'd173) ^ 12'h3C9);
  endfunction

  // Colour memory with one cycle of read latency, gated by prom_ce
  always @(posedge clk) if (prom_ce) prom_data <= mem_word(prom_addr);

  function automatic out_t model(input logic [8:0] a, input logic s, input logic b,
                                 input int lvl);
    logic [11:0] w;
    out_t o;
    w = mem_word(a);
    o.sync  = s;
    o.blank = b;
    o.r = b ? 4'h0 : 4'((int'(w[3:0]) * (lvl + 1)) / 16);
    o.g = b ? 4'h0 : 4'((int'(w[7:4]) * (lvl + 1)) / 16);
    o.b = b ? 4'h0 : 4'((int'(w[11:8]) * (lvl + 1)) / 16);
    return o;
  endfunction

  function automatic out_t cur_out();
    return '{sync: SYNC, blank: BLANK, r: RED, g: GREEN, b: BLUE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, optionally feed the scoreboard, sample #1 after the edge
  task automatic drive(input logic en, input logic [0:0] bk, input logic [7:0] d,
                       input logic s, input logic b, input logic fs, input logic fd,
                       input logic [3:0] fr, input logic sb, input out_t exp);
    out_t e;
    enable = en; BANK = bk; D = d; SYNC_IN = s; BLANK_IN = b;
    fade_start = fs; fade_dir = fd; fade_rate = fr;
    if (en && sb) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    fade_start = 1'b0;
    if (fade_done === 1'b1) done_cnt++;
    if (sb) begin
      if (en) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out", 32'(cur_out()), 32'(e));
        end
      end else begin
        chk("hold_out", 32'(cur_out()), 32'(last_out));
      end
    end
    last_out = cur_out();
  endtask

  task automatic pix(input logic s);
    drive(1'b1, 1'b0, 8'hFF, s, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, BUBBLE);
  endtask

  task automatic tick_pair();
    pix(1'b1);
    pix(1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; fade_start = 1'b0; SYNC_IN = 1'b0; BLANK_IN = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out", 32'(cur_out()), 32'(BUBBLE));
    chk("rst_addr", 32'(prom_addr), 32'h0);
    chk("rst_busy", 32'(fade_busy), 32'h0);
    chk("rst_done", 32'(fade_done), 32'h0);
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(BUBBLE);
    exp_q.push_back(BUBBLE);
    last_out = BUBBLE;
  endtask

  vec_t vecs[16];

  initial begin
    int d0;
    reset = 1'b1; enable = 1'b0; D = '0; BANK = '0; SYNC_IN = 1'b0; BLANK_IN = 1'b0;
    fade_start = 1'b0; fade_dir = 1'b0; fade_rate = '0;
    last_out = BUBBLE;

    // Pixel stream: first entry is bank 1 index 0x35; blank/sync pulses; enable toggling mid-stream
    for (int i = 0; i < 16; i++) begin
      vecs[i].en    = (i >= 6 && i <= 11) ? ~i[0] : 1'b1;
      vecs[i].bank  = (i == 0) ? 1'b1 : 1'(i % 3 == 1);
      vecs[i].d     = (i == 0) ? 8'h35 : 8'(i * 29 + 7);
      vecs[i].sync  = (i == 4 || i == 5 || i == 9);
      vecs[i].blank = (i == 3 || i == 8 || i == 13);
      vecs[i].exp   = model({vecs[i].bank, vecs[i].d}, vecs[i].sync, vecs[i].blank, 15);
    end

    do_reset();
    for (int i = 0; i < 16; i++) begin
      enable = vecs[i].en;
      #1;
      chk("prom_ce", 32'(prom_ce), 32'(vecs[i].en));
      drive(vecs[i].en, vecs[i].bank, vecs[i].d, vecs[i].sync, vecs[i].blank,
            1'b0, 1'b0, 4'h0, 1'b1, vecs[i].exp);
      if (vecs[i].en) chk("prom_addr", 32'(prom_addr), 32'({vecs[i].bank, vecs[i].d}));
    end
    // Explicit check of the 0x135 -> 0xA5C lookup
    chk("first_word", 32'({vecs[0].exp.b, vecs[0].exp.g, vecs[0].exp.r}), 32'hA5C);

    // Fade out from full, two frames per step; a restart request mid-ramp is ignored
    do_reset();
    for (int i = 0; i < 3; i++) pix(1'b0);
    chk("full_level", 32'(RED), 32'hF);
    d0 = done_cnt;
    drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, BUBBLE);
    chk("busy_out", 32'(fade_busy), 32'h1);
    for (int n = 1; n <= 30; n++) begin
      if (n == 10) begin
        drive(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, BUBBLE);
        pix(1'b0);
      end else begin
        tick_pair();
      end
      chk("fade_out_lvl", 32'(RED), 32'(15 - n / 2));
    end
    chk("out_rgb0", 32'({RED, GREEN, BLUE}), 32'h000);
    chk("out_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("out_busy_end", 32'(fade_busy), 32'h0);

    // Fade in from black, one frame per step; a tick in the start cycle is not counted
    d0 = done_cnt;
    drive(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, BUBBLE);
    pix(1'b0);
    chk("busy_in", 32'(fade_busy), 32'h1);
    chk("in_start_lvl", 32'(RED), 32'h0);
    for (int n = 1; n <= 15; n++) begin
      tick_pair();
      if (n == 7) chk("in_lvl7", 32'({RED, GREEN, BLUE}), 32'h777);
    end
    chk("in_full", 32'({RED, GREEN, BLUE}), 32'hFFF);
    chk("in_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("in_busy_end", 32'(fade_busy), 32'h0);

    // Start when already at target: stays idle, done pulses immediately
    drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, BUBBLE);
    chk("tgt_done", 32'(fade_done), 32'h1);
    chk("tgt_busy", 32'(fade_busy), 32'h0);
    pix(1'b0);
    chk("tgt_done_clr", 32'(fade_done), 32'h0);

    // Reset in the middle of a fade
    do_reset();
    for (int i = 0; i < 3; i++) pix(1'b0);
    drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, BUBBLE);
    for (int n = 0; n < 3; n++) tick_pair();
    chk("mid_lvl", 32'(RED), 32'hC);
    chk("mid_busy", 32'(fade_busy), 32'h1);
    d0 = done_cnt;
    do_reset();
    for (int i = 0; i < 3; i++) pix(1'b0);
    chk("post_rst_lvl", 32'({RED, GREEN, BLUE}), 32'hFFF);
    chk("post_rst_done", 32'(done_cnt - d0), 32'd0);
    chk("post_rst_busy", 32'(fade_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
